// File: rtl/dm_store_buffer_if.sv
// Memory-side write port of the store buffer: head entry offered on
// m_req, consumed by the data memory on m_ack.
interface dm_store_buffer_if;
    logic        m_req;
    logic        m_ack;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;

    modport master (
        output m_req,
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        output m_inst_addr,
        input  m_ack
    );

    modport slave (
        input  m_req,
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        input  m_inst_addr,
        output m_ack
    );
endinterface

// File: rtl/dm_store_buffer.sv
// MEM-stage store buffer: formats sb/sh/sw, queues them in a FIFO and
// drains to data memory; flags AdES and load/store word conflicts.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                st_valid,
    input  logic [1:0]          st_op,
    input  logic [31:0]         st_addr,
    input  logic [31:0]         st_data,
    input  logic [31:0]         st_pc,
    output logic                st_ready,
    output logic                st_ades,
    input  logic                ld_check_valid,
    input  logic [31:0]         ld_addr,
    output logic                ld_conflict,
    output logic                empty,
    dm_store_buffer_if.master   mem
);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
        logic [31:0] pc;
    } entry_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    entry_t           fifo_q [DEPTH];
    entry_t           fmt;
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic             hit;

    always_comb begin
        fmt      = '0;
        fmt.addr = {st_addr[31:2], 2'b00};
        fmt.pc   = st_pc;
        unique case (st_op)
            2'b01: begin
                fmt.byteen = 4'b0001 << st_addr[1:0];
                fmt.wdata  = {4{st_data[7:0]}};
            end
            2'b10: begin
                fmt.byteen = st_addr[1] ? 4'b1100 : 4'b0011;
                fmt.wdata  = {2{st_data[15:0]}};
            end
            2'b11: begin
                fmt.byteen = 4'b1111;
                fmt.wdata  = st_data;
            end
            default: ;
        endcase
    end

    assign st_ades  = st_valid
                    & (((st_op == 2'b10) & st_addr[0])
                    |  ((st_op == 2'b11) & (|st_addr[1:0])));
    // Full is judged on the registered count only, so a same-cycle pop
    // never frees a slot for the incoming store.
    assign st_ready = (count != (PTR_W+1)'(DEPTH));
    assign push     = st_valid & (st_op != 2'b00) & ~st_ades & st_ready;
    assign empty    = (count == '0);
    assign pop      = mem.m_req & mem.m_ack;

    assign head               = empty ? '0 : fifo_q[rd_ptr];
    assign mem.m_req          = ~empty;
    assign mem.m_data_addr    = head.addr;
    assign mem.m_data_wdata   = head.wdata;
    assign mem.m_data_byteen  = head.byteen;
    assign mem.m_inst_addr    = head.pc;

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= fmt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // An entry is held when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs = '0;
        hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if (({1'b0, offs} < count)
                && (((fifo_q[i].addr ^ ld_addr) & WORD_MASK) == 32'd0))
                hit = 1'b1;
        end
        ld_conflict = ld_check_valid
                    & (hit | (push & (((fmt.addr ^ ld_addr) & WORD_MASK) == 32'd0)));
    end

endmodule
